calendar_date_counter: RTL and testbench

Registered day/month/year calendar that advances one day per `day_tick` strobe and knows the length of every month. Leap-year handling is selectable by parameter. The block supports validated parallel load and emits single-cycle rollover strobes. It sits behind the seconds/minutes/hours chain of the clock datapath: the hours-wrap pulse drives `day_tick`, and the outputs feed the date display.

---
 rtl/calendar_date_counter.sv | 121 ++++++++++++
 tb/tb_calendar_date_counter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_date_counter.sv
// Day/month/year calendar advanced by day_tick, with validated
// parallel load and registered rollover strobes.
module calendar_date_counter #(
  parameter int YEAR_W    = 7,
  parameter int LEAP_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              day_tick,
  input  logic              load,
  input  logic [3:0]        load_month,
  input  logic [4:0]        load_day,
  input  logic [YEAR_W-1:0] load_year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [YEAR_W-1:0] year,
  output logic [4:0]        numdays,
  output logic              month_wrap,
  output logic              year_wrap,
  output logic              year_ovf,
  output logic              load_err
);

  logic [3:0]        month_q, month_d;
  logic [4:0]        day_q, day_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              month_wrap_q, month_wrap_d;
  logic              year_wrap_q, year_wrap_d;
  logic              year_ovf_q, year_ovf_d;
  logic              load_err_q, load_err_d;
  logic [4:0]        cur_len;
  logic [4:0]        ld_len;
  logic              ld_ok;

  function automatic logic [4:0] month_len(
    input logic [3:0]        m,
    input logic [YEAR_W-1:0] y
  );
    logic leap;
    leap = (LEAP_MODE == 1) && (y[1:0] == 2'b00);
    case (m)
      4'd1:    month_len = leap ? 5'd29 : 5'd28;
      4'd3,
      4'd5,
      4'd8,
      4'd10:   month_len = 5'd30;
      default: month_len = 5'd31;
    endcase
  endfunction

  assign cur_len = month_len(month_q, year_q);
  assign ld_len  = month_len(load_month, load_year);
  assign ld_ok   = (load_month <= 4'd11)
                && (load_day != 5'd0)
                && (load_day <= ld_len);

  always_comb begin
    month_d      = month_q;
    day_d        = day_q;
    year_d       = year_q;
    month_wrap_d = 1'b0;
    year_wrap_d  = 1'b0;
    year_ovf_d   = 1'b0;
    load_err_d   = 1'b0;
    // a load of either kind swallows a coincident tick
    if (load) begin
      if (ld_ok) begin
        month_d = load_month;
        day_d   = load_day;
        year_d  = load_year;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (day_tick) begin
      if (day_q < cur_len) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d        = 5'd1;
        month_wrap_d = 1'b1;
        if (month_q == 4'd11) begin
          month_d     = 4'd0;
          year_d      = year_q + 1'b1;
          year_wrap_d = 1'b1;
          year_ovf_d  = &year_q;
        end else begin
          month_d = month_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      month_q      <= 4'd0;
      day_q        <= 5'd1;
      year_q       <= '0;
      month_wrap_q <= 1'b0;
      year_wrap_q  <= 1'b0;
      year_ovf_q   <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      month_q      <= month_d;
      day_q        <= day_d;
      year_q       <= year_d;
      month_wrap_q <= month_wrap_d;
      year_wrap_q  <= year_wrap_d;
      year_ovf_q   <= year_ovf_d;
      load_err_q   <= load_err_d;
    end
  end

  assign month      = month_q;
  assign day        = day_q;
  assign year       = year_q;
  assign numdays    = cur_len;
  assign month_wrap = month_wrap_q;
  assign year_wrap  = year_wrap_q;
  assign year_ovf   = year_ovf_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Bench for calendar_date_counter: leap and non-leap builds side by
// side, checked against a plain-arithmetic calendar model.
module tb_calendar_date_counter;

  logic       clk;
  logic       rst_n;
  logic       day_tick;
  logic       load;
  logic [3:0] load_month;
  logic [4:0] load_day;
  logic [6:0] load_year;

  logic [3:0] month0, month1;
  logic [4:0] day0, day1, numdays0, numdays1;
  logic [6:0] year0, year1;
  logic       mw0, yw0, ov0, er0;
  logic       mw1, yw1, ov1, er1;

  int n_cmp;
  int n_fail;

  // model state: index 0 = leap build, 1 = no-leap build
  int m_mon[2];
  int m_day[2];
  int m_yr[2];
  bit m_mw[2];
  bit m_yw[2];
  bit m_ov[2];
  bit m_er[2];

  calendar_date_counter #(.YEAR_W(7), .LEAP_MODE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
    .load_month(load_month), .load_day(load_day),
    .load_year(load_year),
    .month(month0), .day(day0), .year(year0), .numdays(numdays0),
    .month_wrap(mw0), .year_wrap(yw0), .year_ovf(ov0),
    .load_err(er0)
  );

  calendar_date_counter #(.YEAR_W(7), .LEAP_MODE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
    .load_month(load_month), .load_day(load_day),
    .load_year(load_year),
    .month(month1), .day(day1), .year(year1), .numdays(numdays1),
    .month_wrap(mw1), .year_wrap(yw1), .year_ovf(ov1),
    .load_err(er1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mlen(input int m, input int y, input bit leap);
    if (m == 1) return (leap && (y % 4 == 0)) ? 29 : 28;
    if (m == 3 || m == 5 || m == 8 || m == 10) return 30;
    return 31;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mon[i] = 0; m_day[i] = 1; m_yr[i] = 0;
      m_mw[i] = 0; m_yw[i] = 0; m_ov[i] = 0; m_er[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit tk, input bit ld,
      input int lm, input int ldy, input int ly);
    for (int i = 0; i < 2; i++) begin
      bit leap;
      leap = (i == 0);
      m_mw[i] = 0; m_yw[i] = 0; m_ov[i] = 0; m_er[i] = 0;
      if (ld) begin
        if (lm <= 11 && ldy >= 1 && ldy <= mlen(lm, ly, leap)) begin
          m_mon[i] = lm; m_day[i] = ldy; m_yr[i] = ly;
        end else begin
          m_er[i] = 1;
        end
      end else if (tk) begin
        if (m_day[i] < mlen(m_mon[i], m_yr[i], leap)) begin
          m_day[i]++;
        end else begin
          m_day[i] = 1;
          m_mw[i] = 1;
          if (m_mon[i] == 11) begin
            m_mon[i] = 0;
            m_yw[i] = 1;
            if (m_yr[i] == 127) begin
              m_yr[i] = 0;
              m_ov[i] = 1;
            end else begin
              m_yr[i]++;
            end
          end else begin
            m_mon[i]++;
          end
        end
      end
    end
  endfunction

  function automatic logic [24:0] observed(input int i);
    if (i == 0)
      return {month0, day0, year0, numdays0, mw0, yw0, ov0, er0};
    return {month1, day1, year1, numdays1, mw1, yw1, ov1, er1};
  endfunction

  function automatic logic [24:0] expected(input int i);
    logic [3:0] m;
    logic [4:0] d;
    logic [6:0] y;
    logic [4:0] n;
    m = 4'(m_mon[i]);
    d = 5'(m_day[i]);
    y = 7'(m_yr[i]);
    n = 5'(mlen(m_mon[i], m_yr[i], i == 0));
    return {m, d, y, n, m_mw[i], m_yw[i], m_ov[i], m_er[i]};
  endfunction

  task automatic drive(input bit tk, input bit ld, input int lm,
      input int ldy, input int ly);
    @(negedge clk);
    day_tick   = tk;
    load       = ld;
    load_month = 4'(lm);
    load_day   = 5'(ldy);
    load_year  = 7'(ly);
    @(posedge clk);
    #1;
    model_step(tk, ld, lm, ldy, ly);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    day_tick = 0; load = 0;
    load_month = 0; load_day = 0; load_year = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (observed(i) !== expected(i)) begin
        n_fail++;
        $display("FAIL reset dut%0d got %h want %h",
                 i, observed(i), expected(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_month_run();
    for (int t = 0; t < 31; t++) begin
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (observed(i) !== expected(i)) begin
          n_fail++;
          $display("FAIL month_run t%0d dut%0d got %h want %h",
                   t, i, observed(i), expected(i));
        end
      end
    end
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (mw0 !== 1'b0 || numdays0 !== 5'd29) begin
      n_fail++;
      $display("FAIL month_run_end got mw=%b nd=%0d want mw=0 nd=29",
               mw0, numdays0);
    end
  endtask

  task automatic test_leap();
    int seq[7][5] = '{
      '{0, 1, 1, 28, 1}, '{1, 0, 0, 0, 0},
      '{0, 1, 1, 28, 4}, '{1, 0, 0, 0, 0}, '{1, 0, 0, 0, 0},
      '{0, 1, 1, 29, 4}, '{0, 0, 0, 0, 0}
    };
    for (int s = 0; s < 7; s++) begin
      drive(seq[s][0][0], seq[s][1][0], seq[s][2], seq[s][3], seq[s][4]);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (observed(i) !== expected(i)) begin
          n_fail++;
          $display("FAIL leap s%0d dut%0d got %h want %h",
                   s, i, observed(i), expected(i));
        end
      end
    end
  endtask

  task automatic test_year_wrap();
    int ys[2] = '{5, 127};
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 11, 31, ys[k]);
      drive(1, 0, 0, 0, 0);
      n_cmp++;
      if (observed(0) !== expected(0) || yw0 !== 1'b1
          || ov0 !== (k == 1)) begin
        n_fail++;
        $display("FAIL year_wrap y%0d got %h want %h",
                 ys[k], observed(0), expected(0));
      end
      drive(0, 0, 0, 0, 0);
      n_cmp++;
      if (observed(0) !== expected(0)) begin
        n_fail++;
        $display("FAIL year_wrap_drop y%0d got %h want %h",
                 ys[k], observed(0), expected(0));
      end
    end
  endtask

  task automatic test_invalid_loads();
    int bad[3][3] = '{'{12, 1, 3}, '{4, 0, 3}, '{3, 31, 3}};
    drive(0, 1, 6, 20, 10);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, bad[k][0], bad[k][1], bad[k][2]);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (observed(i) !== expected(i) || observed(i)[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL invalid_load k%0d dut%0d got %h want %h",
                   k, i, observed(i), expected(i));
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    drive(1, 1, 5, 10, 3);
    n_cmp++;
    if (observed(0) !== expected(0) || day0 !== 5'd10) begin
      n_fail++;
      $display("FAIL load_tick got %h want %h",
               observed(0), expected(0));
    end
    drive(1, 1, 13, 10, 3);
    n_cmp++;
    if (observed(0) !== expected(0) || day0 !== 5'd10) begin
      n_fail++;
      $display("FAIL badload_tick got %h want %h",
               observed(0), expected(0));
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      bit ld, tk;
      ld = ($urandom_range(0, 9) == 0);
      tk = ($urandom_range(0, 3) != 0);
      drive(tk, ld, $urandom_range(0, 13), $urandom_range(0, 31),
            $urandom_range(0, 127));
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (observed(i) !== expected(i)) begin
          n_fail++;
          $display("FAIL random t%0d dut%0d got %h want %h",
                   t, i, observed(i), expected(i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 7, 15, 9);
    @(negedge clk);
    day_tick = 1'b1;
    load = 1'b1;
    load_month = 4'd2;
    load_day = 5'd3;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (observed(i) !== expected(i)) begin
        n_fail++;
        $display("FAIL async_reset dut%0d got %h want %h",
                 i, observed(i), expected(i));
      end
    end
    @(negedge clk);
    day_tick = 1'b0;
    load = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (observed(i) !== expected(i)) begin
        n_fail++;
        $display("FAIL after_release dut%0d got %h want %h",
                 i, observed(i), expected(i));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_month_run();
    test_leap();
    test_year_wrap();
    test_invalid_loads();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
